// File: rtl/mult_pkg.sv
// Shared types for the radix-2 Booth multiplier: datapath control bundle, Booth pair
// encodings and the controller state enum.
package mult_pkg;

  typedef struct packed {
    logic load_A;
    logic load_B;
    logic load_add;
    logic shift_HQ_LQ_Q_1;
    logic add_sub;
    logic clear;
  } mult_control_t;

  // {LQ[0], Q_1} patterns that require an accumulate step
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    EVAL,
    SHIFT,
    DONE
  } ctrl_state_t;

endpackage

// File: rtl/booth_mult_dp.sv
// Radix-2 Booth shift/add datapath: HQ accumulator, LQ multiplier shift register and Q_1.
module booth_mult_dp
  import mult_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic          clk_i,
  input  mult_control_t mult_control_i,
  input  logic [N-1:0]  dp_a_i,
  input  logic [N-1:0]  dp_b_i,
  output logic [1:0]    dp_q_lsb_o,
  output logic [2*N-1:0] dp_y_o
);

  // HQ carries one guard bit so that subtracting -2^(N-1) cannot overflow
  logic [N:0]   hq_q;
  logic [N-1:0] lq_q;
  logic [N-1:0] m_q;
  logic         q1_q;
  logic [N:0]   m_ext;

  assign m_ext = {m_q[N-1], m_q};

  always_ff @(posedge clk_i) begin
    if (mult_control_i.clear) begin
      hq_q <= '0;
      q1_q <= 1'b0;
    end else if (mult_control_i.load_add) begin
      hq_q <= mult_control_i.add_sub ? hq_q + m_ext : hq_q - m_ext;
    end else if (mult_control_i.shift_HQ_LQ_Q_1) begin
      {hq_q, lq_q, q1_q} <= {hq_q[N], hq_q, lq_q};
    end
    if (mult_control_i.load_A) m_q <= dp_a_i;
    if (mult_control_i.load_B) lq_q <= dp_b_i;
  end

  assign dp_q_lsb_o = {lq_q[0], q1_q};
  assign dp_y_o     = {hq_q[N-1:0], lq_q};

endmodule

// File: rtl/mult_top.sv
// Booth multiplier wrapper: sequencing controller plus shift/add datapath.
module mult_top
  import mult_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [N-1:0]   in_a_i,
  input  logic [N-1:0]   in_b_i,
  input  logic           abort_i,
  output logic           busy_o,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [2*N-1:0] out_product_o
);

  logic [1:0]     dp_q_lsb;
  logic [2*N-1:0] dp_y;
  logic [N-1:0]   dp_a, dp_b;
  mult_control_t  mult_control;

  booth_mult_ctrl #(.N(N)) u_ctrl (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_a_i         (in_a_i),
    .in_b_i         (in_b_i),
    .abort_i        (abort_i),
    .dp_q_lsb_i     (dp_q_lsb),
    .dp_y_i         (dp_y),
    .dp_a_o         (dp_a),
    .dp_b_o         (dp_b),
    .mult_control_o (mult_control),
    .busy_o         (busy_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_product_o  (out_product_o)
  );

  booth_mult_dp #(.N(N)) u_dp (
    .clk_i          (clk_i),
    .mult_control_i (mult_control),
    .dp_a_i         (dp_a),
    .dp_b_i         (dp_b),
    .dp_q_lsb_o     (dp_q_lsb),
    .dp_y_o         (dp_y)
  );

endmodule

// File: rtl/booth_mult_ctrl.sv
// Sequencing FSM for the radix-2 Booth shift/add multiplier: accepts an operand pair,
// steps the datapath through N evaluate/shift iterations and hands back the product.
module booth_mult_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [N-1:0]  in_a_i,
  input  logic [N-1:0]  in_b_i,
  input  logic          abort_i,
  input  logic [1:0]    dp_q_lsb_i,
  input  logic [2*N-1:0] dp_y_i,
  output logic [N-1:0]  dp_a_o,
  output logic [N-1:0]  dp_b_o,
  output mult_control_t mult_control_o,
  output logic          busy_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [2*N-1:0] out_product_o
);

  localparam int unsigned CntW = $clog2(N);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  ctrl_state_t   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic          in_ready_q, busy_q, out_valid_q;
  mult_control_t ctrl;
  logic          running;

  assign running = (state_q == CLEAR) || (state_q == LOAD) ||
                   (state_q == EVAL)  || (state_q == SHIFT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl    = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d     = in_a_i;
          b_d     = in_b_i;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        ctrl.clear = 1'b1;
        state_d    = LOAD;
      end
      LOAD: begin
        ctrl.load_A = 1'b1;
        ctrl.load_B = 1'b1;
        state_d     = EVAL;
      end
      EVAL: begin
        if (dp_q_lsb_i == BOOTH_ADD) begin
          ctrl.load_add = 1'b1;
          ctrl.add_sub  = 1'b1;
        end else if (dp_q_lsb_i == BOOTH_SUB) begin
          ctrl.load_add = 1'b1;
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        ctrl.shift_HQ_LQ_Q_1 = 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CntW'(1);
          state_d = EVAL;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort suppresses the datapath update of the current cycle as well
    if (abort_i && running) begin
      state_d = IDLE;
      cnt_d   = cnt_q;
      ctrl    = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      in_ready_q  <= (state_d == IDLE);
      busy_q      <= (state_d == CLEAR) || (state_d == LOAD) ||
                     (state_d == EVAL)  || (state_d == SHIFT);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign in_ready_o     = in_ready_q;
  assign busy_o         = busy_q;
  assign out_valid_o    = out_valid_q;
  assign dp_a_o         = a_q;
  assign dp_b_o         = b_q;
  assign mult_control_o = ctrl;
  assign out_product_o  = dp_y_i;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Bench for booth_mult_ctrl driving the Booth datapath; products checked against integer math.
module tb_booth_mult_ctrl;
  import mult_pkg::*;

  localparam int unsigned N = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, abort, busy, out_valid, out_ready;
  logic [N-1:0]   in_a, in_b, dp_a, dp_b;
  logic [1:0]     dp_q_lsb;
  logic [2*N-1:0] dp_y, out_product;
  mult_control_t  mult_control;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  booth_mult_ctrl #(.N(N)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_a_i         (in_a),
    .in_b_i         (in_b),
    .abort_i        (abort),
    .dp_q_lsb_i     (dp_q_lsb),
    .dp_y_i         (dp_y),
    .dp_a_o         (dp_a),
    .dp_b_o         (dp_b),
    .mult_control_o (mult_control),
    .busy_o         (busy),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_product_o  (out_product)
  );

  booth_mult_dp #(.N(N)) u_dp (
    .clk_i          (clk),
    .mult_control_i (mult_control),
    .dp_a_i         (dp_a),
    .dp_b_i         (dp_b),
    .dp_q_lsb_o     (dp_q_lsb),
    .dp_y_o         (dp_y)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_product(input logic [7:0] a, input logic [7:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 16'(sa * sb);
  endfunction

  // Booth recoding: a 0->1 transition of the multiplier (LSB first) subtracts, 1->0 adds
  task automatic ref_booth(input logic [7:0] b, output int adds, output int subs);
    logic prev;
    prev = 1'b0;
    adds = 0;
    subs = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i] && !prev) subs++;
      if (!b[i] && prev) adds++;
      prev = b[i];
    end
  endtask

  function automatic bit ctrl_ok(input mult_control_t c);
    if ($countones(c) <= 1) return 1'b1;
    if ($countones(c) == 2 && c.load_A && c.load_B) return 1'b1;
    if ($countones(c) == 2 && c.load_add && c.add_sub) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ctrl"}, {26'b0, mult_control}, 32'd0);
    check({tag, "_dp_a"}, 32'(dp_a), 32'd0);
    check({tag, "_dp_b"}, 32'(dp_b), 32'd0);
  endtask

  // Handshake one operand pair; returns in cycle 1 (CLEAR) after the accept edge
  task automatic start(input logic [7:0] a, input logic [7:0] b);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = 8'($urandom);
    in_b = 8'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold);
    int cyc, adds, subs, e_adds, e_subs;
    bit bad;
    logic [15:0] prod;
    start(a, b);
    check("dp_a_capt", 32'(dp_a), 32'(a));
    check("dp_b_capt", 32'(dp_b), 32'(b));
    cyc = 1;
    adds = 0;
    subs = 0;
    bad = 1'b0;
    while (!out_valid && cyc < 60) begin
      if (mult_control.load_add && mult_control.add_sub) adds++;
      if (mult_control.load_add && !mult_control.add_sub) subs++;
      if (!ctrl_ok(mult_control)) bad = 1'b1;
      tick();
      cyc++;
    end
    ref_booth(b, e_adds, e_subs);
    check("latency", 32'(cyc), 32'd19);
    check("product", 32'(out_product), 32'(ref_product(a, b)));
    check("add_evals", 32'(adds), 32'(e_adds));
    check("sub_evals", 32'(subs), 32'(e_subs));
    check("ctrl_exclusive", 32'(bad), 32'd0);
    if (hold > 0) begin
      prod = ref_product(a, b);
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        tick();
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_product", 32'(out_product), 32'(prod));
        check("hold_in_ready", 32'(in_ready), 32'd0);
        check("hold_ctrl", {26'b0, mult_control}, 32'd0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int nshift, w;
    bit seen_valid;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    abort = 1'b0;
    out_ready = 1'b0;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_op(8'd3, 8'd5, 0);
    run_op(8'hFD, 8'd7, 0);
    run_op(8'h80, 8'h80, 5);
    run_op(8'd2, 8'd2, 0);

    // Abort on the fourth SHIFT (k = 3)
    start(8'd7, 8'd3);
    nshift = 0;
    w = 0;
    while (w < 40) begin
      if (mult_control.shift_HQ_LQ_Q_1) begin
        if (nshift == 3) break;
        nshift++;
      end
      tick();
      w++;
    end
    check("abort_reached_k3", 32'(mult_control.shift_HQ_LQ_Q_1), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ctrl", {26'b0, mult_control}, 32'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid || mult_control != '0) seen_valid = 1'b1;
      tick();
    end
    check("abort_quiet", 32'(seen_valid), 32'd0);
    run_op(8'd6, 8'hF9, 0);

    // Asynchronous reset during the k = 4 EVAL (cycle 11)
    start(8'd5, 8'd3);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    tick();
    rst = 1'b0;
    tick();
    run_op(8'd2, 8'd2, 0);

    for (int i = 0; i < 8; i++) begin
      run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
